frame_window_rw: RTL and testbench

Parametrised window engine between the playfield grid memory and the piece/frame logic. On command, it scans a WIN×WIN window anchored at a signed origin, one cell per clock, through a single-port-style grid interface. Three operations are supported: LOAD (grid → frame), CHECK (collision test of a supplied frame against the grid) and WRITE (frame → grid, overwrite or merge). Off-grid cells are handled explicitly, so pieces may sit partly outside the playfield.

---
 rtl/frame_pkg.sv | 27 ++
 rtl/window_scan.sv | 71 +++++++
 rtl/frame_window_rw.sv | 193 +++++++++++++++++++
 tb/tb_frame_window_rw.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared types for the playfield window engines: operation codes, engine states,
// the grid cell type and the window cell index helper.
package frame_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_CHECK = 2'd1,
        OP_WRITE = 2'd2,
        OP_NOP   = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int CELL_W = 3;
    typedef logic [CELL_W-1:0] cell_t;

    // Row-major position of window cell (r,c) in a packed WIN x WIN frame.
    function automatic int cell_idx(input int r, input int c, input int win);
        return r * win + c;
    endfunction

endpackage

// File: rtl/window_scan.sv
// Row-major WIN x WIN cell walker: counter, signed grid position and in-grid test.
// Position outputs are combinational from the counter; the counter advances on step.
module window_scan
    import frame_pkg::*;
#(
    parameter int GRID_ROWS = 20,
    parameter int GRID_COLS = 10,
    parameter int WIN       = 5,
    parameter int OW        = 6,
    parameter int RA        = $clog2(GRID_ROWS),
    parameter int CA        = $clog2(GRID_COLS),
    parameter int IW        = $clog2(WIN*WIN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 step,
    input  logic signed [OW-1:0] row_org,
    input  logic signed [OW-1:0] col_org,
    output logic [IW-1:0]        idx,
    output logic                 last,
    output logic                 in_grid,
    output logic                 above,
    output logic [RA-1:0]        row_addr,
    output logic [CA-1:0]        col_addr
);

    localparam int RW = $clog2(WIN);
    localparam logic signed [OW:0] ROWS_S = (OW+1)'(GRID_ROWS);
    localparam logic signed [OW:0] COLS_S = (OW+1)'(GRID_COLS);

    logic [RW-1:0]     r;
    logic [RW-1:0]     c;
    logic signed [OW:0] pr;
    logic signed [OW:0] pc;
    logic              row_ok;
    logic              col_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
            c <= '0;
        end else if (clr) begin
            r <= '0;
            c <= '0;
        end else if (step && !last) begin
            if (c == RW'(WIN-1)) begin
                c <= '0;
                r <= r + 1'b1;
            end else begin
                c <= c + 1'b1;
            end
        end
    end

    assign last = (r == RW'(WIN-1)) && (c == RW'(WIN-1));
    assign idx  = IW'(cell_idx(int'(r), int'(c), WIN));

    // One extra bit so origin + offset can never wrap.
    assign pr = $signed({row_org[OW-1], row_org}) + $signed({{(OW+1-RW){1'b0}}, r});
    assign pc = $signed({col_org[OW-1], col_org}) + $signed({{(OW+1-RW){1'b0}}, c});

    assign row_ok  = !pr[OW] && (pr < ROWS_S);
    assign col_ok  = !pc[OW] && (pc < COLS_S);
    assign in_grid = row_ok && col_ok;
    assign above   = pr[OW] && col_ok;

    assign row_addr = pr[RA-1:0];
    assign col_addr = pc[CA-1:0];

endmodule

// File: rtl/frame_window_rw.sv
// Window engine: LOAD/CHECK/WRITE a WIN x WIN frame against the grid, one cell per clock.
// LOAD/CHECK finish in N+2 cycles, WRITE in N+1; start is ignored while busy, abort returns to idle.
module frame_window_rw
    import frame_pkg::*;
#(
    parameter int            GRID_ROWS   = 20,
    parameter int            GRID_COLS   = 10,
    parameter int            WIN         = 5,
    parameter int            CW          = 3,
    parameter logic [CW-1:0] OOB_FILL    = 3'd7,
    parameter bit            ALLOW_ABOVE = 1'b1,
    parameter int            RA          = $clog2(GRID_ROWS),
    parameter int            CA          = $clog2(GRID_COLS),
    parameter int            OW          = $clog2(((GRID_ROWS > GRID_COLS) ? GRID_ROWS : GRID_COLS) + WIN) + 1,
    parameter int            N           = WIN*WIN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic                 merge,
    input  logic signed [OW-1:0] row_org,
    input  logic signed [OW-1:0] col_org,
    input  logic [N*CW-1:0]      frame_in,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 hit,
    output logic [N*CW-1:0]      frame_out,
    output logic                 grid_re,
    output logic [RA-1:0]        grid_rrow,
    output logic [CA-1:0]        grid_rcol,
    input  logic [CW-1:0]        grid_rdata,
    output logic                 grid_we,
    output logic [RA-1:0]        grid_wrow,
    output logic [CA-1:0]        grid_wcol,
    output logic [CW-1:0]        grid_wdata
);

    localparam int IW = $clog2(N);
    localparam int NB = N*CW;

    state_t              state;
    state_t              state_nxt;
    op_t                 op_q;
    logic                merge_q;
    logic signed [OW-1:0] row_q;
    logic signed [OW-1:0] col_q;
    logic [NB-1:0]       frame_q;

    logic                accept;
    logic                scanning;
    logic [IW-1:0]       idx;
    logic                last;
    logic                in_grid;
    logic                above;
    logic [RA-1:0]       row_addr;
    logic [CA-1:0]       col_addr;
    logic [CW-1:0]       cur_cell;
    logic                rd_op;
    logic                wr_cell;

    logic                cap_vld;
    logic [IW-1:0]       cap_idx;
    logic                cap_in;
    logic                cap_fnz;
    logic                cap_ohit;
    logic [CW-1:0]       cap_val;
    logic                cell_hit;
    logic [NB-1:0]       frame_buf;
    logic [NB-1:0]       buf_nxt;
    logic                hit_acc;
    logic                hit_nxt;

    assign accept   = ((state == ST_IDLE) || (state == ST_DONE)) && start && !abort;
    assign scanning = (state == ST_SCAN);

    window_scan #(
        .GRID_ROWS (GRID_ROWS),
        .GRID_COLS (GRID_COLS),
        .WIN       (WIN),
        .OW        (OW),
        .RA        (RA),
        .CA        (CA),
        .IW        (IW)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .step     (scanning),
        .row_org  (row_q),
        .col_org  (col_q),
        .idx      (idx),
        .last     (last),
        .in_grid  (in_grid),
        .above    (above),
        .row_addr (row_addr),
        .col_addr (col_addr)
    );

    assign cur_cell = frame_q[idx*CW +: CW];
    assign rd_op    = (op_q == OP_LOAD) || (op_q == OP_CHECK);
    assign wr_cell  = scanning && (op_q == OP_WRITE) && in_grid && !(merge_q && (cur_cell == '0));

    assign grid_re    = scanning && rd_op && in_grid;
    assign grid_rrow  = grid_re ? row_addr : '0;
    assign grid_rcol  = grid_re ? col_addr : '0;
    assign grid_we    = wr_cell;
    assign grid_wrow  = wr_cell ? row_addr : '0;
    assign grid_wcol  = wr_cell ? col_addr : '0;
    assign grid_wdata = wr_cell ? cur_cell : '0;

    assign busy = (state == ST_SCAN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (abort)      state_nxt = ST_IDLE;
                else if (start) state_nxt = (op_t'(op) == OP_NOP) ? ST_DONE : ST_SCAN;
                else            state_nxt = ST_IDLE;
            end
            ST_SCAN: begin
                if (abort)     state_nxt = ST_IDLE;
                else if (last) state_nxt = (op_q == OP_WRITE) ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: state_nxt = abort ? ST_IDLE : ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Off-grid cells ride the same one-cycle slot as reads so captures stay in order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vld  <= 1'b0;
            cap_idx  <= '0;
            cap_in   <= 1'b0;
            cap_fnz  <= 1'b0;
            cap_ohit <= 1'b0;
        end else begin
            cap_vld  <= scanning && rd_op;
            cap_idx  <= idx;
            cap_in   <= in_grid;
            cap_fnz  <= (cur_cell != '0);
            cap_ohit <= !in_grid && !(ALLOW_ABOVE && above);
        end
    end

    assign cap_val  = cap_in ? grid_rdata : OOB_FILL;
    assign cell_hit = cap_vld && cap_fnz && (cap_in ? (grid_rdata != '0) : cap_ohit);
    assign hit_nxt  = hit_acc || cell_hit;

    always_comb begin
        buf_nxt = frame_buf;
        if (cap_vld) buf_nxt[cap_idx*CW +: CW] = cap_val;
    end

    // Results are staged in frame_buf/hit_acc and published only on completion,
    // so an aborted operation leaves frame_out untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_LOAD;
            merge_q   <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            frame_q   <= '0;
            frame_buf <= '0;
            hit_acc   <= 1'b0;
            hit       <= 1'b0;
            frame_out <= '0;
        end else begin
            state     <= state_nxt;
            frame_buf <= buf_nxt;
            hit_acc   <= hit_nxt;
            if (accept) begin
                op_q    <= op_t'(op);
                merge_q <= merge;
                row_q   <= row_org;
                col_q   <= col_org;
                frame_q <= frame_in;
                hit_acc <= 1'b0;
                hit     <= 1'b0;
            end
            if ((state == ST_DRAIN) && !abort) begin
                if (op_q == OP_LOAD)  frame_out <= buf_nxt;
                if (op_q == OP_CHECK) hit       <= hit_nxt;
            end
        end
    end

endmodule

// File: tb/tb_frame_window_rw.sv
// Directed and randomized checks of frame_window_rw against a cell-level model of the grid.
module tb_frame_window_rw;

    localparam int GR  = 20;
    localparam int GC  = 10;
    localparam int WIN = 5;
    localparam int CW  = 3;
    localparam int N   = WIN*WIN;
    localparam int NB  = N*CW;
    localparam int OW  = 6;
    localparam int RA  = 5;
    localparam int CA  = 4;
    localparam logic [CW-1:0] OOB = 3'd7;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [1:0]           op;
    logic                 merge;
    logic signed [OW-1:0] row_org;
    logic signed [OW-1:0] col_org;
    logic [NB-1:0]        frame_in;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic                 hit;
    logic [NB-1:0]        frame_out;
    logic                 grid_re;
    logic [RA-1:0]        grid_rrow;
    logic [CA-1:0]        grid_rcol;
    logic [CW-1:0]        grid_rdata;
    logic                 grid_we;
    logic [RA-1:0]        grid_wrow;
    logic [CA-1:0]        grid_wcol;
    logic [CW-1:0]        grid_wdata;

    frame_window_rw dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .merge      (merge),
        .row_org    (row_org),
        .col_org    (col_org),
        .frame_in   (frame_in),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .hit        (hit),
        .frame_out  (frame_out),
        .grid_re    (grid_re),
        .grid_rrow  (grid_rrow),
        .grid_rcol  (grid_rcol),
        .grid_rdata (grid_rdata),
        .grid_we    (grid_we),
        .grid_wrow  (grid_wrow),
        .grid_wcol  (grid_wcol),
        .grid_wdata (grid_wdata)
    );

    always #5 clk = ~clk;

    // Grid memory seen by the DUT, and the model's idea of what it should hold.
    logic [CW-1:0] mem      [GR][GC];
    logic [CW-1:0] ref_grid [GR][GC];
    logic          sync_req = 1'b0;

    always @(posedge clk) begin
        if (sync_req) begin
            for (int i = 0; i < GR; i++)
                for (int j = 0; j < GC; j++)
                    mem[i][j] <= ref_grid[i][j];
        end else if (grid_we) begin
            mem[grid_wrow][grid_wcol] <= grid_wdata;
        end
        if (grid_re) grid_rdata <= mem[grid_rrow][grid_rcol];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit on_grid(input int pr, input int pc);
        return (pr >= 0) && (pr < GR) && (pc >= 0) && (pc < GC);
    endfunction

    function automatic logic [CW-1:0] fcell(input logic [NB-1:0] f, input int r, input int c);
        return f[(r*WIN+c)*CW +: CW];
    endfunction

    function automatic logic [NB-1:0] put(input logic [NB-1:0] f, input int r, input int c,
                                          input logic [CW-1:0] v);
        logic [NB-1:0] t;
        t = f;
        t[(r*WIN+c)*CW +: CW] = v;
        return t;
    endfunction

    function automatic logic [NB-1:0] exp_load(input int ro, input int co);
        logic [NB-1:0] f;
        f = '0;
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                f = put(f, r, c, on_grid(ro+r, co+c) ? ref_grid[ro+r][co+c] : OOB);
        return f;
    endfunction

    function automatic logic exp_hit(input int ro, input int co, input logic [NB-1:0] f);
        logic h;
        h = 1'b0;
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++) begin
                if (fcell(f, r, c) != '0) begin
                    if (on_grid(ro+r, co+c)) begin
                        if (ref_grid[ro+r][co+c] != '0) h = 1'b1;
                    end else if (!((ro+r) < 0 && (co+c) >= 0 && (co+c) < GC)) begin
                        h = 1'b1;
                    end
                end
            end
        return h;
    endfunction

    function automatic int exp_reads(input int ro, input int co);
        int n;
        n = 0;
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                if (on_grid(ro+r, co+c)) n++;
        return n;
    endfunction

    function automatic int exp_writes(input int ro, input int co, input logic [NB-1:0] f, input logic m);
        int n;
        n = 0;
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                if (on_grid(ro+r, co+c) && !(m && fcell(f, r, c) == '0)) n++;
        return n;
    endfunction

    task automatic apply_write(input int ro, input int co, input logic [NB-1:0] f, input logic m,
                               input int limit);
        for (int k = 0; k < limit; k++) begin
            int r;
            int c;
            r = k / WIN;
            c = k % WIN;
            if (on_grid(ro+r, co+c) && !(m && fcell(f, r, c) == '0))
                ref_grid[ro+r][co+c] = fcell(f, r, c);
        end
    endtask

    function automatic int grid_diffs();
        int n;
        n = 0;
        for (int i = 0; i < GR; i++)
            for (int j = 0; j < GC; j++)
                if (mem[i][j] !== ref_grid[i][j]) n++;
        return n;
    endfunction

    function automatic int count_oob(input logic [NB-1:0] f);
        int n;
        n = 0;
        for (int k = 0; k < N; k++)
            if (f[k*CW +: CW] == OOB) n++;
        return n;
    endfunction

    function automatic int exp_done_cycle(input logic [1:0] o);
        if (o == 2'd3) return 1;
        if (o == 2'd2) return N + 1;
        return N + 2;
    endfunction

    task automatic sync_mem();
        @(negedge clk);
        sync_req = 1'b1;
        @(negedge clk);
        sync_req = 1'b0;
    endtask

    // ---------------- operation driver ----------------
    int            o_done;
    int            o_re;
    int            o_we;
    int            o_fwe;
    int            o_lwe;
    logic          o_busy_after;
    logic [RA-1:0] o_wrow;
    logic [CA-1:0] o_wcol;
    logic [CW-1:0] o_wdata;

    // Cycle 0 is the cycle start is high; outputs of cycle k are sampled at its falling edge.
    task automatic run_op(input logic [1:0] o, input logic m, input int ro, input int co,
                          input logic [NB-1:0] f, input int abort_at, input int dup_at);
        @(negedge clk);
        op = o; merge = m; row_org = OW'(ro); col_org = OW'(co); frame_in = f; start = 1'b1;
        o_done = -1; o_re = 0; o_we = 0; o_fwe = -1; o_lwe = -1; o_busy_after = 1'b1;
        o_wrow = '0; o_wcol = '0; o_wdata = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (grid_re) o_re++;
            if (grid_we) begin
                o_we++;
                if (o_fwe < 0) begin
                    o_fwe = k; o_wrow = grid_wrow; o_wcol = grid_wcol; o_wdata = grid_wdata;
                end
                o_lwe = k;
            end
            if (done && o_done < 0) o_done = k;
            if (k == abort_at + 1) o_busy_after = busy;
            start = (k == dup_at);
            abort = (k == abort_at);
            if (o_done >= 0 && abort_at < 0) break;
            if (abort_at >= 0 && k >= abort_at + 4) break;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    logic [NB-1:0] exp_f;
    logic [NB-1:0] last_frame;
    logic [NB-1:0] tpiece;
    logic [NB-1:0] rf;
    logic [1:0]    rop;
    logic          rm;
    int            ro;
    int            co;

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'd0; merge = 1'b0; abort = 1'b0;
        row_org = '0; col_org = '0; frame_in = '0;
        for (int i = 0; i < GR; i++)
            for (int j = 0; j < GC; j++)
                ref_grid[i][j] = '0;
        ref_grid[2][3] = 3'd5;
        sync_mem();
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_outputs", {done, hit, grid_re, grid_we, grid_rrow, grid_rcol, grid_wrow, grid_wcol, grid_wdata}, '0);
        check("rst_frame_out", frame_out, '0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", {busy, done, hit, grid_re, grid_we}, '0);

        // LOAD at the origin: one nonzero grid cell
        run_op(2'd0, 1'b0, 0, 0, '0, -1, -1);
        exp_f = put('0, 2, 3, 3'd5);
        check("load0_done_cycle", o_done, 27);
        check("load0_reads", o_re, 25);
        check("load0_frame", frame_out, exp_f);
        check("load0_hit", hit, 1'b0);

        // LOAD straddling the top and right edges
        run_op(2'd0, 1'b0, -2, 8, '0, -1, -1);
        check("load_edge_reads", o_re, 6);
        check("load_edge_oob_cells", count_oob(frame_out), 19);
        check("load_edge_frame", frame_out, exp_load(-2, 8));
        last_frame = frame_out;

        // CHECK of a T piece near the floor and above the ceiling
        tpiece = put(put(put(put('0, 0, 1, 3'd1), 0, 2, 3'd1), 0, 3, 3'd1), 1, 2, 3'd1);
        run_op(2'd1, 1'b0, 18, 4, tpiece, -1, -1);
        check("chk_floor_done", o_done, 27);
        check("chk_floor_hit", hit, 1'b0);
        run_op(2'd1, 1'b0, 19, 4, tpiece, -1, -1);
        check("chk_below_hit", hit, 1'b1);
        run_op(2'd1, 1'b0, -3, 4, tpiece, -1, -1);
        check("chk_above_hit", hit, 1'b0);
        check("chk_frame_held", frame_out, last_frame);

        // WRITE merge with a single nonzero cell
        run_op(2'd2, 1'b1, 5, 5, put('0, 0, 0, 3'd2), -1, -1);
        apply_write(5, 5, put('0, 0, 0, 3'd2), 1'b1, N);
        check("wr_merge_count", o_we, 1);
        check("wr_merge_cycle", o_fwe, 1);
        check("wr_merge_addr", {o_wrow, o_wcol}, {5'd5, 4'd5});
        check("wr_merge_data", o_wdata, 3'd2);
        check("wr_merge_done", o_done, 26);
        check("wr_merge_grid", grid_diffs(), 0);

        // WRITE aborted at cycle 10, with an ignored start at cycle 5
        rf = '0;
        for (int k = 0; k < N; k++) rf[k*CW +: CW] = 3'($urandom_range(7, 1));
        run_op(2'd2, 1'b0, 0, 0, rf, 10, 5);
        apply_write(0, 0, rf, 1'b0, 10);
        check("abort_no_done", o_done, -1);
        check("abort_last_we_by_10", (o_lwe <= 10), 1'b1);
        check("abort_busy_after", o_busy_after, 1'b0);
        check("abort_grid", grid_diffs(), 0);

        run_op(2'd3, 1'b0, 0, 0, '0, -1, -1);
        check("nop_done", o_done, 1);
        check("nop_no_access", o_re + o_we, 0);

        // Reset in the middle of a LOAD
        @(negedge clk);
        op = 2'd0; row_org = '0; col_org = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("midrst_re_before", grid_re, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_outputs", {busy, done, hit, grid_re, grid_we, grid_rrow, grid_rcol, grid_wrow, grid_wcol, grid_wdata}, '0);
        check("midrst_frame_out", frame_out, '0);
        @(negedge clk);
        check("midrst_no_read", grid_re, 1'b0);
        rst = 1'b0;
        run_op(2'd0, 1'b0, 1, 3, '0, -1, -1);
        check("postrst_done", o_done, 27);
        check("postrst_frame", frame_out, exp_load(1, 3));
        last_frame = frame_out;

        // Randomized operations against the model
        for (int it = 0; it < 40; it++) begin
            if (it % 10 == 0) begin
                for (int i = 0; i < GR; i++)
                    for (int j = 0; j < GC; j++)
                        ref_grid[i][j] = ($urandom_range(1, 0) == 0) ? 3'd0 : 3'($urandom_range(6, 1));
                sync_mem();
            end
            rop = 2'($urandom_range(3, 0));
            rm  = 1'($urandom_range(1, 0));
            ro  = int'($urandom_range(27, 0)) - 6;
            co  = int'($urandom_range(17, 0)) - 6;
            rf  = '0;
            for (int k = 0; k < N; k++)
                if ($urandom_range(2, 0) == 0) rf[k*CW +: CW] = 3'($urandom_range(7, 1));
            exp_f = exp_load(ro, co);
            run_op(rop, rm, ro, co, rf, -1, -1);
            check("rnd_done_cycle", o_done, exp_done_cycle(rop));
            case (rop)
                2'd0: begin
                    check("rnd_load_reads", o_re, exp_reads(ro, co));
                    check("rnd_load_frame", frame_out, exp_f);
                    last_frame = exp_f;
                end
                2'd1: begin
                    check("rnd_chk_reads", o_re, exp_reads(ro, co));
                    check("rnd_chk_hit", hit, exp_hit(ro, co, rf));
                    check("rnd_chk_frame_held", frame_out, last_frame);
                end
                2'd2: begin
                    check("rnd_wr_count", o_we, exp_writes(ro, co, rf, rm));
                    apply_write(ro, co, rf, rm, N);
                    check("rnd_wr_grid", grid_diffs(), 0);
                end
                default: begin
                    check("rnd_nop_access", o_re + o_we, 0);
                    check("rnd_nop_frame_held", frame_out, last_frame);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
